// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types for the FIFO drain arbiter: state encoding, header fill pattern, count width helper.
// Optional header words are built from HDR_MARK when FIFO_DRAIN_HEADER_EN is defined.
package fifo_drain_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HDR        = 3'd1,
        ST_BURST      = 3'd2,
        ST_FLUSH_WAIT = 3'd3,
        ST_FLUSH_RST  = 3'd4
    } state_t;

    localparam logic [63:0] HDR_MARK = '1;

    function automatic int burst_cnt_w(input int log_burst);
        return (log_burst < 1) ? 1 : log_burst;
    endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping NUM_CH-1 -> 0.
// Purely combinational; no backpressure.
module rr_pick #(
    parameter int NUM_CH     = 4,
    parameter int LOG_NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]     i_req,
    input  logic [LOG_NUM_CH-1:0] i_ptr,
    output logic [LOG_NUM_CH-1:0] o_grant,
    output logic                  o_any
);

    function automatic logic [LOG_NUM_CH-1:0] wrap_idx(input int k);
        return LOG_NUM_CH'(k % NUM_CH);
    endfunction

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[wrap_idx(int'(i_ptr) + i)]) begin
                o_grant = wrap_idx(int'(i_ptr) + i);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of NUM_CH show-ahead FIFOs into one registered valid/ready stream, plus flush sequencing.
// Pop -> OUT_VALID latency 1 cycle; pops only when the output slot is free. Macro FIFO_DRAIN_HEADER_EN adds a header word per burst.
module fifo_drain_arbiter
    import fifo_drain_arbiter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int LOG_NUM_CH = 2,
    parameter int LOG_BURST  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_flush,
    input  logic [NUM_CH-1:0]       i_fifo_empty,
    input  logic [NUM_CH*WIDTH-1:0] i_fifo_data,
    output logic [NUM_CH-1:0]       o_fifo_re,
    output logic [NUM_CH-1:0]       o_fifo_soft_rst,
    output logic [WIDTH-1:0]        o_out_data,
    output logic [LOG_NUM_CH-1:0]   o_out_ch,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_out_last,
    output logic                    o_busy
);

    localparam int             CW       = burst_cnt_w(LOG_BURST);
    localparam logic [CW-1:0]  LAST_CNT = CW'((1 << LOG_BURST) - 1);

    state_t                r_state;
    logic [LOG_NUM_CH-1:0] r_ptr;
    logic [LOG_NUM_CH-1:0] r_grant;
    logic [CW-1:0]         r_count;
    logic                  r_out_vld;
    logic                  r_out_last;
    logic [WIDTH-1:0]      r_out_dat;
    logic [LOG_NUM_CH-1:0] r_out_ch;

    logic [LOG_NUM_CH-1:0] w_pick;
    logic                  w_any;
    logic [LOG_NUM_CH-1:0] w_next_ptr;
    logic                  w_slot_free;
    logic                  w_grant_empty;
    logic [WIDTH-1:0]      w_grant_dat;
    logic [WIDTH-1:0]      w_hdr;
    logic                  w_flush_req;
    logic                  w_pop;

    rr_pick #(
        .NUM_CH    (NUM_CH),
        .LOG_NUM_CH(LOG_NUM_CH)
    ) u_rr_pick (
        .i_req  (~i_fifo_empty),
        .i_ptr  (r_ptr),
        .o_grant(w_pick),
        .o_any  (w_any)
    );

    assign w_next_ptr    = (w_pick == LOG_NUM_CH'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
    assign w_slot_free   = ~r_out_vld | i_out_ready;
    assign w_grant_empty = i_fifo_empty[r_grant];
    assign w_grant_dat   = i_fifo_data[r_grant*WIDTH +: WIDTH];
    assign w_hdr         = {HDR_MARK[WIDTH-LOG_NUM_CH-1:0], r_grant};
    assign w_flush_req   = i_flush & (r_state != ST_FLUSH_WAIT) & (r_state != ST_FLUSH_RST);
    // A flush request in the same cycle suppresses the pop so nothing is lost mid-flush.
    assign w_pop         = (r_state == ST_BURST) & ~w_flush_req & w_slot_free & ~w_grant_empty & i_enable;

    assign o_fifo_re       = w_pop ? (NUM_CH'(1) << r_grant) : '0;
    assign o_fifo_soft_rst = {NUM_CH{r_state == ST_FLUSH_RST}};
    assign o_out_data      = r_out_dat;
    assign o_out_ch        = r_out_ch;
    assign o_out_valid     = r_out_vld;
    assign o_out_last      = r_out_last;
    assign o_busy          = (r_state != ST_IDLE) | r_out_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_count    <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_dat  <= '0;
            r_out_ch   <= '0;
        end else begin
            if (w_slot_free) begin
                r_out_vld <= 1'b0;
            end
            if (w_flush_req) begin
                r_state <= ST_FLUSH_WAIT;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_enable & w_any) begin
                            r_grant <= w_pick;
                            r_ptr   <= w_next_ptr;
                            r_count <= '0;
`ifdef FIFO_DRAIN_HEADER_EN
                            r_state <= ST_HDR;
`else
                            r_state <= ST_BURST;
`endif
                        end
                    end
                    ST_HDR: begin
                        if (w_slot_free) begin
                            r_out_vld  <= 1'b1;
                            r_out_dat  <= w_hdr;
                            r_out_ch   <= r_grant;
                            r_out_last <= 1'b0;
                            r_state    <= ST_BURST;
                        end
                    end
                    ST_BURST: begin
                        if (w_pop) begin
                            r_out_vld  <= 1'b1;
                            r_out_dat  <= w_grant_dat;
                            r_out_ch   <= r_grant;
                            r_out_last <= (r_count == LAST_CNT);
                            r_count    <= r_count + 1'b1;
                            if (r_count == LAST_CNT) begin
                                r_state <= ST_IDLE;
                            end
                        end else if (w_slot_free) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_FLUSH_WAIT: begin
                        if (!r_out_vld) begin
                            r_state <= ST_FLUSH_RST;
                        end
                    end
                    ST_FLUSH_RST: begin
                        r_ptr   <= '0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
